uart_rx_fsm: RTL and testbench

Control state machine of the UART receiver. It detects a falling edge on the line, sequences one frame (start, 8 data bits, optional parity, stop), and drives the enables of the edge/bit counter, data sampler, start/parity/stop checkers and deserializer. It consumes `strt_glitch`, `par_err` and `stp_err` from the checkers and issues a one-cycle `data_valid` for each error-free frame.

---
 rtl/uart_rx_pkg.sv | 36 +++
 rtl/uart_rx_fsm.sv | 105 ++++++++++
 tb/tb_uart_rx_fsm.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver: FSM states, prescale legal values,
// frame geometry and counter widths.
package uart_rx_pkg;

  localparam int unsigned PRESCALE_W = 6;
  localparam int unsigned EDGE_CNT_W = 5;
  localparam int unsigned BIT_CNT_W  = 4;

  localparam int unsigned DATA_BITS_DEF = 8;

  localparam logic [PRESCALE_W-1:0] PRESCALE_8  = 6'd8;
  localparam logic [PRESCALE_W-1:0] PRESCALE_16 = 6'd16;
  localparam logic [PRESCALE_W-1:0] PRESCALE_32 = 6'd32;

  localparam logic [BIT_CNT_W-1:0] START_IDX = 4'd0;
  localparam logic [BIT_CNT_W-1:0] PAR_IDX   = 4'd9;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_t;

  // Map any unsupported oversampling ratio onto 8.
  function automatic logic [PRESCALE_W-1:0] map_prescale(input logic [PRESCALE_W-1:0] p);
    logic [PRESCALE_W-1:0] r;
    case (p)
      PRESCALE_8, PRESCALE_16, PRESCALE_32: r = p;
      default:                              r = PRESCALE_8;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/uart_rx_fsm.sv
// UART receiver control FSM: detects the start edge, walks one frame and
// enables the counter, sampler, checkers and deserializer bit by bit.
module uart_rx_fsm
  import uart_rx_pkg::*;
#(
  parameter int unsigned DATA_BITS = DATA_BITS_DEF
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RX_IN,
  input  logic       PAR_EN,
  input  logic [5:0] prescale,
  input  logic [4:0] edge_cnt,
  input  logic [3:0] bit_cnt,
  input  logic       strt_glitch,
  input  logic       par_err,
  input  logic       stp_err,
  output logic       cnt_en,
  output logic       dat_samp_en,
  output logic       strt_chk_en,
  output logic       deser_en,
  output logic       par_chk_en,
  output logic       stp_chk_en,
  output logic       data_valid
);

  rx_state_t             state, state_nxt;
  logic                  par_en_q, par_en_nxt;
  logic                  data_valid_nxt;
  logic [PRESCALE_W-1:0] eff_prescale;
  logic                  last_edge;

  // Last oversampling edge of the current bit, compared in counter width.
  always_comb begin
    eff_prescale = map_prescale(prescale);
    last_edge    = (edge_cnt == EDGE_CNT_W'(eff_prescale - 6'd1));
  end

  // State, latched parity mode and the registered frame-good pulse.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= ST_IDLE;
      par_en_q   <= 1'b0;
      data_valid <= 1'b0;
    end else begin
      state      <= state_nxt;
      par_en_q   <= par_en_nxt;
      data_valid <= data_valid_nxt;
    end
  end

  // Next-state logic; errors sampled only on the last edge of their bit.
  always_comb begin
    state_nxt      = state;
    par_en_nxt     = par_en_q;
    data_valid_nxt = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!RX_IN) begin
          state_nxt  = ST_START;
          par_en_nxt = PAR_EN;
        end
      end
      ST_START: begin
        if (last_edge) state_nxt = strt_glitch ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (last_edge && (bit_cnt == BIT_CNT_W'(DATA_BITS)))
          state_nxt = par_en_q ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: begin
        if (last_edge) state_nxt = par_err ? ST_IDLE : ST_STOP;
      end
      ST_STOP: begin
        if (last_edge) begin
          state_nxt      = ST_IDLE;
          data_valid_nxt = !stp_err;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Moore enables decoded from the state register.
  always_comb begin
    cnt_en      = 1'b0;
    dat_samp_en = 1'b0;
    strt_chk_en = 1'b0;
    deser_en    = 1'b0;
    par_chk_en  = 1'b0;
    stp_chk_en  = 1'b0;
    case (state)
      ST_START:  strt_chk_en = 1'b1;
      ST_DATA:   deser_en    = 1'b1;
      ST_PARITY: par_chk_en  = 1'b1;
      ST_STOP:   stp_chk_en  = 1'b1;
      default:   ;
    endcase
    if (state != ST_IDLE) begin
      cnt_en      = 1'b1;
      dat_samp_en = 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Bench for uart_rx_fsm: a behavioural edge/bit counter feeds the FSM, and a
// frame-timeline model predicts every output in every cycle.
module tb_uart_rx_fsm;

  logic       CLK;
  logic       RST;
  logic       RX_IN;
  logic       PAR_EN;
  logic [5:0] prescale;
  logic [4:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       strt_glitch, par_err, stp_err;
  logic       cnt_en, dat_samp_en, strt_chk_en, deser_en, par_chk_en, stp_chk_en;
  logic       data_valid;
  logic [6:0] obs;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Current frame timeline: start cycle, bit length, bit count, parity mode.
  int fs     = -1;
  int f_p    = 8;
  int f_nb   = 0;
  bit f_par  = 1'b0;
  int dv_cyc = -1;

  uart_rx_fsm dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .prescale(prescale),
    .edge_cnt(edge_cnt), .bit_cnt(bit_cnt), .strt_glitch(strt_glitch),
    .par_err(par_err), .stp_err(stp_err), .cnt_en(cnt_en), .dat_samp_en(dat_samp_en),
    .strt_chk_en(strt_chk_en), .deser_en(deser_en), .par_chk_en(par_chk_en),
    .stp_chk_en(stp_chk_en), .data_valid(data_valid)
  );

  assign obs = {cnt_en, dat_samp_en, strt_chk_en, deser_en, par_chk_en, stp_chk_en, data_valid};

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic int eff_ps(input logic [5:0] p);
    return (p == 6'd8 || p == 6'd16 || p == 6'd32) ? int'(p) : 8;
  endfunction

  // Environment edge/bit counter driven by the FSM's cnt_en.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (!cnt_en) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (int'(edge_cnt) == eff_ps(prescale) - 1) begin
      edge_cnt <= '0;
      bit_cnt  <= bit_cnt + 4'd1;
    end else begin
      edge_cnt <= edge_cnt + 5'd1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // Expected outputs {cnt,samp,strt,deser,par,stp,dv} from the frame timeline.
  function automatic logic [6:0] exp_out(input int t);
    logic [6:0] o;
    int off, b;
    o = '0;
    if (t == dv_cyc) o[0] = 1'b1;
    off = t - fs - 1;
    if (fs >= 0 && off >= 0 && off < f_nb * f_p) begin
      b = off / f_p;
      o[6] = 1'b1;
      o[5] = 1'b1;
      if (b == 0)                o[4] = 1'b1;
      else if (b <= 8)           o[3] = 1'b1;
      else if (b == 9 && f_par)  o[2] = 1'b1;
      else                       o[1] = 1'b1;
    end
    return o;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
    check_eq("outs", 32'(obs), 32'(exp_out(cyc)));
  endtask

  task automatic noise();
    strt_glitch = 1'($urandom);
    par_err     = 1'($urandom);
    stp_err     = 1'($urandom);
  endtask

  // err: 0 good, 1 start glitch, 2 parity error, 3 stop error.
  // rst_at > 0 pulls reset during frame cycle rst_at.
  task automatic run_frame(input logic [5:0] ps, input bit par, input int err_in,
                           input int gap, input logic [7:0] d, input int rst_at);
    int err;
    int off, b, e;
    bit last;
    err = (err_in == 2 && !par) ? 0 : err_in;
    repeat (gap) begin
      tick();
      RX_IN  = 1'b1;
      PAR_EN = 1'($urandom);
      noise();
    end
    tick();
    fs     = cyc;
    f_p    = eff_ps(ps);
    f_par  = par;
    f_nb   = (err == 1) ? 1 : (err == 2) ? 10 : 10 + int'(par);
    dv_cyc = (err == 0) ? fs + 1 + f_nb * f_p : -1;
    prescale = ps;
    PAR_EN   = par;
    RX_IN    = 1'b0;
    noise();
    for (int t = 1; t <= f_nb * f_p; t++) begin
      tick();
      off  = t - 1;
      b    = off / f_p;
      e    = off % f_p;
      last = (e == f_p - 1);
      noise();
      PAR_EN = 1'($urandom);
      if (b == 0)      RX_IN = (err == 1 && e >= 2) ? 1'b1 : 1'b0;
      else if (b <= 8) RX_IN = d[b-1];
      else if (b == 9 && par) RX_IN = ^d;
      else             RX_IN = 1'b1;
      if (b == 0 && last)                 strt_glitch = (err == 1);
      if (b == 9 && par && last)          par_err     = (err == 2);
      if (b == 9 + int'(par) && last)     stp_err     = (err == 3);
      if (t == rst_at) begin
        #2 RST = 1'b0;
        RX_IN = 1'b1;
        #1 check_eq("rst_async", 32'(obs), 32'd0);
        fs     = -1;
        dv_cyc = -1;
        tick();
        RST = 1'b1;
        return;
      end
    end
  endtask

  initial begin
    logic [5:0] ps;
    int r, err, rst_at;
    RST = 1'b0; RX_IN = 1'b1; PAR_EN = 1'b0; prescale = 6'd8;
    strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0;
    repeat (3) tick();
    RST = 1'b1;

    run_frame(6'd8,  1'b0, 0, 2, 8'hA5, 0);
    run_frame(6'd16, 1'b1, 0, 2, 8'h3C, 0);
    run_frame(6'd8,  1'b0, 1, 2, 8'h00, 0);
    run_frame(6'd32, 1'b1, 2, 2, 8'h5A, 0);
    run_frame(6'd32, 1'b1, 3, 2, 8'h5A, 0);
    run_frame(6'd8,  1'b0, 0, 2, 8'h11, 0);
    run_frame(6'd8,  1'b0, 0, 0, 8'h22, 0);
    run_frame(6'd8,  1'b0, 0, 2, 8'h33, 4 * 8 + 3);
    run_frame(6'd8,  1'b1, 0, 1, 8'h44, 0);
    run_frame(6'd40, 1'b0, 0, 0, 8'h55, 0);
    run_frame(6'd0,  1'b1, 3, 1, 8'h66, 0);

    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 3);
      if (r == 0)      ps = 6'd8;
      else if (r == 1) ps = 6'd16;
      else if (r == 2) ps = 6'd32;
      else begin
        ps = 6'($urandom_range(0, 63));
        if (ps == 6'd8 || ps == 6'd16 || ps == 6'd32) ps = 6'd1;
      end
      r   = $urandom_range(0, 5);
      err = (r <= 2) ? 0 : r - 2;
      rst_at = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 80) : 0;
      run_frame(ps, 1'($urandom), err, $urandom_range(0, 3), 8'($urandom), rst_at);
    end
    repeat (4) begin
      tick();
      RX_IN = 1'b1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
